tcam_pipelined: RTL
===================

# tcam_pipelined

Native-RTL ternary CAM with parametrised depth, width and match priority. Each entry has a valid bit, and entries can be invalidated individually or all at once. Lookups use a valid/ready handshake, run in a two-stage pipeline and carry a tag through. It is the next-generation lookup core for output-port and header-classification tables. It replaces the vendor CAM primitive and adds multi-match reporting and back-pressure.

## Interface
- C_TCAM_ADDR_WIDTH, 5: entry address width; depth = 2**C_TCAM_ADDR_WIDTH.
- C_TCAM_DATA_WIDTH, 32: key/entry width.
- C_TCAM_TAG_WIDTH, 8: opaque lookup tag width, carried to the result.
- C_MATCH_PRIORITY, 0: 0 = lowest matching address wins; 1 = highest wins.
- CLK  in  1  clock.
- RESETN  in  1  reset; asynchronous, active-low.
- WE  in  1  write strobe; accepted only when BUSY=0.
- WR_ADDR  in  C_TCAM_ADDR_WIDTH  entry to write.
- DIN  in  C_TCAM_DATA_WIDTH  entry value.
- DATA_MASK  in  C_TCAM_DATA_WIDTH  entry mask; 1 = don't-care bit.
- WR_VALID  in  1  valid bit written with the entry; 0 invalidates the entry.
- CLR_ALL  in  1  invalidate all entries; accepted only when BUSY=0; takes priority over WE in the same cycle.
- BUSY  out  1  table update in progress.
- LKP_VALID  in  1  lookup request valid.
- LKP_READY  out  1  lookup request accepted when LKP_VALID and LKP_READY are both 1.
- CMP_DIN  in  C_TCAM_DATA_WIDTH  lookup key.
- CMP_DATA_MASK  in  C_TCAM_DATA_WIDTH  key mask; 1 = don't-care bit.
- LKP_TAG  in  C_TCAM_TAG_WIDTH  request tag.
- RES_VALID  out  1  result valid.
- RES_READY  in  1  result consumed when RES_VALID and RES_READY are both 1.
- MATCH  out  1  at least one valid entry matched.
- MULTI_MATCH  out  1  two or more valid entries matched.
- MATCH_ADDR  out  C_TCAM_ADDR_WIDTH  winning entry; 0 when MATCH=0.
- RES_TAG  out  C_TCAM_TAG_WIDTH  tag of the request that produced this result.

## Operation
- Entry i matches when both hold:
  - valid[i] = 1;
  - (entry_val[i] ^ CMP_DIN) & ~entry_mask[i] & ~CMP_DATA_MASK == 0.
- Write: WE accepted at cycle t updates entry value, mask and valid at the clock edge ending cycle t. BUSY is 1 during cycle t+1.
- CLR_ALL accepted at cycle t clears every valid bit. BUSY is 1 during cycle t+1.
- Value and mask storage is not reset; only the valid bits are.
- WE or CLR_ALL while BUSY=1: ignored; no storage change.
- Lookups are blocked while the table changes: LKP_READY = !BUSY && !(WE || CLR_ALL) && (stage1 empty || pipeline advancing).
- Stage 1 (compare): registers the match vector and tag.
- Stage 2 (encode): registers MATCH, MULTI_MATCH, MATCH_ADDR and RES_TAG.
- Stall: when RES_VALID=1 and RES_READY=0, both stages hold and all result outputs stay stable.
- Reset: all valid bits 0 and both pipeline stages empty. Outputs: BUSY=0, RES_VALID=0, MATCH=0, MULTI_MATCH=0, MATCH_ADDR=0, RES_TAG=0. LKP_READY=1 after the first edge with RESETN=1.
- Reset asserted mid-lookup: in-flight requests are discarded and no result is produced.

## Timing
- Lookup latency: request accepted at t gives RES_VALID at t+2 when there is no stall.
- Throughput: one lookup per cycle with RES_READY held at 1.
- Write-to-lookup ordering: a write accepted at t is visible to lookups accepted at t+2 or later. Lookups already in the pipeline use the table as it was when their compare was registered.
- LKP_READY is registered-path-free only with respect to RES_READY; the combinational path RES_READY to LKP_READY is allowed.
- No combinational path from LKP_VALID to any output.

## Structure
- tcam_pkg holds:
  - priority encode function and popcount-≥2 function;
  - localparam C_TCAM_DEPTH;
  - typedefs for entry value and mask.
- Sub-module tcam_prio_enc: match vector in; MATCH, MULTI_MATCH and MATCH_ADDR out; C_MATCH_PRIORITY selects direction. Purely combinational, instanced inside stage 2.
- Storage is flop arrays in the top module; no RAM inference.

## Test plan
- Reset, then look up key 0x0000_0000 with mask 0 → RES_VALID at t+2 with MATCH=0, MULTI_MATCH=0, MATCH_ADDR=0 and the tag echoed.
- Write entry 3 = 0x1234_0000 with mask 0x0000_FFFF and entry 7 = 0x1234_5678 with mask 0. Look up 0x1234_5678:
  - C_MATCH_PRIORITY=0 → MATCH=1, MULTI_MATCH=1, MATCH_ADDR=3;
  - C_MATCH_PRIORITY=1 → MATCH_ADDR=7.
- Write entry 3 with WR_VALID=0, then look up 0x1234_5678 → MATCH_ADDR=7, MULTI_MATCH=0.
- Then CLR_ALL and the same lookup → MATCH=0. BUSY is 1 for exactly one cycle after each update, and WE during BUSY leaves the table unchanged.
- Stream 8 back-to-back lookups with tags 0..7 while RES_READY toggles 1,0,0,1 → results in order with no loss or duplication. Outputs stay stable while stalled, and LKP_READY=0 while both stages are full and stalled.
- Assert RESETN low while two lookups are in flight → RES_VALID=0 immediately, no stale result after release, and all entries invalid.

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared definitions for the pipelined ternary CAM.
//   - default geometry and C_TCAM_DEPTH for the default address width
//   - entry value / mask typedefs at the default data width
//   - table-update state type
//   - priority-encode and "two or more set" helpers operating on a
//     zero-extended match vector of up to C_TCAM_MAX_DEPTH entries
package tcam_pkg;

  localparam int unsigned C_TCAM_DEF_ADDR_WIDTH = 5;
  localparam int unsigned C_TCAM_DEF_DATA_WIDTH = 32;
  localparam int unsigned C_TCAM_DEPTH          = 2**C_TCAM_DEF_ADDR_WIDTH;
  // Upper bound on table depth supported by the helper functions.
  localparam int unsigned C_TCAM_MAX_DEPTH      = 256;

  typedef logic [C_TCAM_DEF_DATA_WIDTH-1:0] tcam_data_t;
  typedef logic [C_TCAM_DEF_DATA_WIDTH-1:0] tcam_mask_t;
  typedef logic [C_TCAM_MAX_DEPTH-1:0]      tcam_vec_t;

  typedef enum logic {
    UPD_IDLE = 1'b0,
    UPD_BUSY = 1'b1
  } upd_state_t;

  // Index of the lowest (highest = 0) or highest (highest = 1) set bit;
  // 0 when no bit is set.
  function automatic int unsigned prio_encode(input tcam_vec_t vec, input bit highest);
    int unsigned idx;
    idx = 0;
    if (highest) begin
      for (int unsigned i = 0; i < C_TCAM_MAX_DEPTH; i++) begin
        if (vec[i]) idx = i;
      end
    end else begin
      for (int unsigned i = C_TCAM_MAX_DEPTH; i > 0; i--) begin
        if (vec[i-1]) idx = i - 1;
      end
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic at_least_two(input tcam_vec_t vec);
    return |(vec & (vec - tcam_vec_t'(1)));
  endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Combinational match-vector encoder.
//   match_vec   : one bit per entry, 1 = entry matched
//   match       : at least one bit set
//   multi_match : two or more bits set
//   match_addr  : winning entry (lowest or highest per C_MATCH_PRIORITY), 0 if none
module tcam_prio_enc
  import tcam_pkg::*;
#(
  parameter int unsigned C_TCAM_ADDR_WIDTH = C_TCAM_DEF_ADDR_WIDTH,
  parameter int unsigned C_MATCH_PRIORITY  = 0
) (
  input  logic [2**C_TCAM_ADDR_WIDTH-1:0] match_vec,
  output logic                            match,
  output logic                            multi_match,
  output logic [C_TCAM_ADDR_WIDTH-1:0]    match_addr
);

  tcam_vec_t vec_ext;

  always_comb begin
    vec_ext = '0;
    vec_ext[2**C_TCAM_ADDR_WIDTH-1:0] = match_vec;
  end

  assign match       = |match_vec;
  assign multi_match = at_least_two(vec_ext);
  assign match_addr  = C_TCAM_ADDR_WIDTH'(prio_encode(vec_ext, C_MATCH_PRIORITY != 0));

endmodule

// File: rtl/tcam_pipelined.sv
// Pipelined ternary CAM with per-entry valid bits and handshaked lookups.
//   CLK, RESETN                      : clock, async active-low reset
//   WE, WR_ADDR, DIN, DATA_MASK,
//   WR_VALID                         : entry write (mask bit 1 = don't care)
//   CLR_ALL                          : invalidate every entry (wins over WE)
//   BUSY                             : table update in progress (one cycle)
//   LKP_VALID/LKP_READY, CMP_DIN,
//   CMP_DATA_MASK, LKP_TAG           : lookup request
//   RES_VALID/RES_READY, MATCH,
//   MULTI_MATCH, MATCH_ADDR, RES_TAG : lookup result
// Stage 1 registers the match vector and tag, stage 2 the encoded result.
module tcam_pipelined
  import tcam_pkg::*;
#(
  parameter int unsigned C_TCAM_ADDR_WIDTH = C_TCAM_DEF_ADDR_WIDTH,
  parameter int unsigned C_TCAM_DATA_WIDTH = C_TCAM_DEF_DATA_WIDTH,
  parameter int unsigned C_TCAM_TAG_WIDTH  = 8,
  parameter int unsigned C_MATCH_PRIORITY  = 0
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         WE,
  input  logic [C_TCAM_ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [C_TCAM_DATA_WIDTH-1:0] DIN,
  input  logic [C_TCAM_DATA_WIDTH-1:0] DATA_MASK,
  input  logic                         WR_VALID,
  input  logic                         CLR_ALL,
  output logic                         BUSY,
  input  logic                         LKP_VALID,
  output logic                         LKP_READY,
  input  logic [C_TCAM_DATA_WIDTH-1:0] CMP_DIN,
  input  logic [C_TCAM_DATA_WIDTH-1:0] CMP_DATA_MASK,
  input  logic [C_TCAM_TAG_WIDTH-1:0]  LKP_TAG,
  output logic                         RES_VALID,
  input  logic                         RES_READY,
  output logic                         MATCH,
  output logic                         MULTI_MATCH,
  output logic [C_TCAM_ADDR_WIDTH-1:0] MATCH_ADDR,
  output logic [C_TCAM_TAG_WIDTH-1:0]  RES_TAG
);

  localparam int unsigned C_DEPTH = 2**C_TCAM_ADDR_WIDTH;

  // Table storage: value and mask are plain flops without reset.
  logic [C_TCAM_DATA_WIDTH-1:0] entry_val  [C_DEPTH];
  logic [C_TCAM_DATA_WIDTH-1:0] entry_mask [C_DEPTH];
  logic [C_DEPTH-1:0]           entry_valid;

  upd_state_t upd_state, upd_state_next;
  logic       upd_idle;
  logic       clr_fire;
  logic       wr_fire;

  logic [C_DEPTH-1:0]           cmp_vec;
  logic                         lkp_fire;
  logic                         stall;

  logic                         s1_valid;
  logic [C_DEPTH-1:0]           s1_vec;
  logic [C_TCAM_TAG_WIDTH-1:0]  s1_tag;

  logic                         enc_match;
  logic                         enc_multi;
  logic [C_TCAM_ADDR_WIDTH-1:0] enc_addr;

  logic                         s2_valid;
  logic                         s2_match;
  logic                         s2_multi;
  logic [C_TCAM_ADDR_WIDTH-1:0] s2_addr;
  logic [C_TCAM_TAG_WIDTH-1:0]  s2_tag;

  // ---------------------------------------------------------------------
  // Table update control: an accepted update always costs one busy cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) upd_state <= UPD_IDLE;
    else         upd_state <= upd_state_next;
  end

  always_comb begin
    upd_state_next = UPD_IDLE;
    if (upd_state == UPD_IDLE && (WE || CLR_ALL)) upd_state_next = UPD_BUSY;
  end

  assign upd_idle = (upd_state == UPD_IDLE);
  assign clr_fire = upd_idle && CLR_ALL;
  assign wr_fire  = upd_idle && WE && !CLR_ALL;
  assign BUSY     = (upd_state == UPD_BUSY);

  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      entry_val[WR_ADDR]  <= DIN;
      entry_mask[WR_ADDR] <= DATA_MASK;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)       entry_valid          <= '0;
    else if (clr_fire) entry_valid          <= '0;
    else if (wr_fire)  entry_valid[WR_ADDR] <= WR_VALID;
  end

  // ---------------------------------------------------------------------
  // Compare against the current table contents.
  // ---------------------------------------------------------------------
  always_comb begin
    cmp_vec = '0;
    for (int unsigned i = 0; i < C_DEPTH; i++) begin
      cmp_vec[i] = entry_valid[i] &&
                   (((entry_val[i] ^ CMP_DIN) & ~entry_mask[i] & ~CMP_DATA_MASK) == '0);
    end
  end

  // ---------------------------------------------------------------------
  // Two-stage pipeline. Stage 1 may still accept while stalled if it is
  // empty; once both stages are full and stalled, lookups are refused.
  // ---------------------------------------------------------------------
  assign stall     = s2_valid && !RES_READY;
  assign LKP_READY = upd_idle && !(WE || CLR_ALL) && (!s1_valid || !stall);
  assign lkp_fire  = LKP_VALID && LKP_READY;

  tcam_prio_enc #(
    .C_TCAM_ADDR_WIDTH (C_TCAM_ADDR_WIDTH),
    .C_MATCH_PRIORITY  (C_MATCH_PRIORITY)
  ) u_prio_enc (
    .match_vec   (s1_vec),
    .match       (enc_match),
    .multi_match (enc_multi),
    .match_addr  (enc_addr)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_match <= 1'b0;
      s2_multi <= 1'b0;
      s2_addr  <= '0;
      s2_tag   <= '0;
    end else begin
      s1_valid <= lkp_fire || (s1_valid && stall);
      if (lkp_fire) begin
        s1_vec <= cmp_vec;
        s1_tag <= LKP_TAG;
      end
      if (!stall) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_match <= enc_match;
          s2_multi <= enc_multi;
          s2_addr  <= enc_addr;
          s2_tag   <= s1_tag;
        end
      end
    end
  end

  assign RES_VALID   = s2_valid;
  assign MATCH       = s2_match;
  assign MULTI_MATCH = s2_multi;
  assign MATCH_ADDR  = s2_addr;
  assign RES_TAG     = s2_tag;

endmodule
